// File: rtl/ai_mc_wr_serializer.sv
// Write-back serializer: turns a job (base address, beat count) plus an OFM word stream into
// single-outstanding AW/W/B bursts, split at MAX_BURST beats and MAX_BURST-aligned boundaries.
//
// state  | meaning
// S_IDLE | waiting for a job command
// S_ADDR | burst address presented, waiting for aw_ready
// S_DATA | streaming burst beats from the input FIFO
// S_RESP | waiting for the write response of the burst
// S_FIN  | one-cycle job completion pulse
module ai_mc_wr_serializer #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_err,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BPW  = DATA_W / 8;
  localparam int AOFF = $clog2(BPW);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = (LEN_W > 9) ? LEN_W : 9;
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(BPW - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [7:0]        beat_q, beat_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              push, pop, fifo_full, fifo_empty, job_phase;
  logic [8:0]        cur_beats;
  logic [ADDR_W-1:0] cmd_addr_al;

  // Beats until the nearest of: job end, MAX_BURST, next MAX_BURST-aligned word boundary.
  function automatic logic [8:0] burst_beats(input logic [ADDR_W-1:0] a,
                                             input logic [LEN_W-1:0]  r);
    logic [ADDR_W-1:0] word;
    logic [8:0]        room;
    word = a >> AOFF;
    room = 9'(MAX_BURST) - 9'(word & ADDR_W'(MAX_BURST - 1));
    if (CW'(r) < CW'(room)) burst_beats = 9'(r);
    else                    burst_beats = room;
  endfunction

  assign fifo_full   = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (cnt_q == '0);
  assign job_phase   = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_RESP);
  assign cur_beats   = {1'b0, aw_len_q} + 9'd1;
  assign cmd_addr_al = cmd_addr & AMASK;

  assign cmd_ready = rst && (state_q == S_IDLE);
  assign in_ready  = job_phase && !fifo_full && (acc_q < len_q);
  assign aw_valid  = (state_q == S_ADDR);
  assign aw_addr   = aw_addr_q;
  assign aw_len    = aw_len_q;
  assign w_valid   = (state_q == S_DATA) && !fifo_empty;
  assign w_data    = w_valid ? mem_q[rptr_q] : '0;
  assign w_last    = w_valid && (beat_q == 8'd0);
  assign b_ready   = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;

  assign push = in_valid && in_ready;
  assign pop  = w_valid && w_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    acc_d     = acc_q;
    err_d     = err_q;
    aw_addr_d = aw_addr_q;
    aw_len_d  = aw_len_q;
    beat_d    = beat_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;

    if (push) begin
      mem_d[wptr_q] = in_data;
      wptr_d        = wptr_q + 1'b1;
      acc_d         = acc_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr_al;
          rem_d  = cmd_len;
          len_d  = cmd_len;
          acc_d  = '0;
          err_d  = 1'b0;
          if (cmd_len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_ADDR;
            aw_addr_d = cmd_addr_al;
            aw_len_d  = 8'(burst_beats(cmd_addr_al, cmd_len) - 9'd1);
          end
        end
      end
      S_ADDR: begin
        if (aw_ready) begin
          beat_d  = aw_len_q;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pop) begin
          if (beat_q == 8'd0) begin
            state_d = S_RESP;
            addr_d  = addr_q + (ADDR_W'(cur_beats) << AOFF);
            rem_d   = rem_q - LEN_W'(cur_beats);
          end else begin
            beat_d = beat_q - 8'd1;
          end
        end
      end
      S_RESP: begin
        if (b_valid) begin
          err_d = err_q | b_err;
          if (rem_q != '0) begin
            state_d   = S_ADDR;
            aw_addr_d = addr_q;
            aw_len_d  = 8'(burst_beats(addr_q, rem_q) - 9'd1);
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      beat_q    <= '0;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      aw_addr_q <= aw_addr_d;
      aw_len_q  <= aw_len_d;
      beat_q    <= beat_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ai_mc_wr_serializer.sv
// Bench for ai_mc_wr_serializer: randomized handshakes checked every cycle against a
// job/burst/word-queue model, plus literal expectations for the directed cases.
module tb_ai_mc_wr_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        aw_valid;
  logic        aw_ready = 1'b0;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_data;
  logic        w_last;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic        b_err = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  ai_mc_wr_serializer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus knobs (percent probabilities, max B delay)
  int p_in, p_w, p_aw, bd_max, p_spur;
  logic [31:0] berr_mask = '0;

  // model: phase 0 idle, 1 job running, 2 completion cycle
  int          phase = 0;
  logic [31:0] bq_addr[$];
  logic [7:0]  bq_len[$];
  logic [31:0] exp_q[$];
  bit          aw_done = 0, wait_b = 0, rst_applied = 1, err_m = 0;
  bit          cmd_pend = 0, job_started = 0;
  int          beats_sent = 0, cur_len = 0, acc = 0, job_len = 0, burst_idx = 0, b_wait = 0;

  // observation
  logic [31:0] src_q[$];
  logic [31:0] aw_log_a[$];
  logic [7:0]  aw_log_l[$];
  logic [31:0] w_log[$];
  logic        wl_log[$];
  int          done_cnt, aw_seen, cmd_cyc, done_cyc;
  logic        err_at_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic build_bursts(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int r, off, b;
    bq_addr.delete();
    bq_len.delete();
    a = addr & 32'hFFFF_FFFC;
    r = len;
    while (r > 0) begin
      off = int'((a >> 2) % 32'd16);
      b = r;
      if (b > 16) b = 16;
      if (b > 16 - off) b = 16 - off;
      bq_addr.push_back(a);
      bq_len.push_back(8'(b - 1));
      a = a + 32'(4 * b);
      r -= b;
    end
  endtask

  task automatic model_reset();
    phase = 0; aw_done = 0; wait_b = 0; err_m = 0; acc = 0; job_len = 0;
    beats_sent = 0; cur_len = 0; burst_idx = 0; cmd_pend = 0;
    bq_addr.delete(); bq_len.delete(); exp_q.delete(); src_q.delete();
  endtask

  task automatic step();
    bit e_aw, e_w, e_in;
    @(negedge clk);
    cyc++;
    if (!rst && rst_applied) begin
      chk("rst_ctrl_zero", 64'({cmd_ready, in_ready, aw_valid, w_valid, w_last,
                                b_ready, busy, done, err}), 64'(0));
      chk("rst_aw_zero", 64'({aw_addr, aw_len}), 64'(0));
      chk("rst_wdata_zero", 64'(w_data), 64'(0));
    end else begin
      e_aw = (phase == 1) && !aw_done && !wait_b;
      e_w  = (phase == 1) && aw_done && (exp_q.size() > 0);
      e_in = (phase == 1) && (exp_q.size() < 4) && (acc < job_len);
      chk("cmd_ready", 64'(cmd_ready), 64'((phase == 0) && rst));
      chk("busy", 64'(busy), 64'(phase != 0));
      chk("done", 64'(done), 64'(phase == 2));
      chk("err", 64'(err), 64'(err_m));
      chk("aw_valid", 64'(aw_valid), 64'(e_aw));
      chk("w_valid", 64'(w_valid), 64'(e_w));
      chk("b_ready", 64'(b_ready), 64'(wait_b));
      chk("in_ready", 64'(in_ready), 64'(e_in));
      if (e_aw && aw_valid && bq_addr.size() > 0) begin
        chk("aw_addr", 64'(aw_addr), 64'(bq_addr[0]));
        chk("aw_len", 64'(aw_len), 64'(bq_len[0]));
      end
      if (e_w && w_valid) begin
        chk("w_data", 64'(w_data), 64'(exp_q[0]));
        chk("w_last", 64'(w_last), 64'(beats_sent == cur_len - 1));
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc; err_at_done = err; end
    if (aw_valid) aw_seen++;

    if (!rst) begin
      model_reset();
      rst_applied = 1;
    end else begin
      rst_applied = 0;
      if (phase == 2) phase = 0;
      if (cmd_valid && cmd_ready) begin
        cmd_pend = 0; job_started = 1; cmd_cyc = cyc;
        build_bursts(cmd_addr, int'(cmd_len));
        job_len = int'(cmd_len); acc = 0; err_m = 0; aw_done = 0; wait_b = 0; burst_idx = 0;
        phase = (cmd_len == 0) ? 2 : 1;
      end
      if (aw_valid && aw_ready) begin
        aw_log_a.push_back(aw_addr);
        aw_log_l.push_back(aw_len);
        aw_done = 1; beats_sent = 0;
        if (bq_len.size() > 0) begin
          cur_len = int'(bq_len[0]) + 1;
          void'(bq_addr.pop_front());
          void'(bq_len.pop_front());
        end else begin
          cur_len = int'(aw_len) + 1;
        end
      end
      if (w_valid && w_ready) begin
        w_log.push_back(w_data);
        wl_log.push_back(w_last);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats_sent++;
        if (beats_sent >= cur_len) begin
          aw_done = 0; wait_b = 1;
          b_wait = int'($urandom_range(bd_max, 0));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (b_valid && b_ready) begin
        err_m = err_m | b_err;
        wait_b = 0;
        burst_idx++;
        if (bq_addr.size() == 0 && phase == 1) phase = 2;
      end
    end

    @(posedge clk);
    #1;
    cmd_valid = cmd_pend;
    in_valid  = ($urandom_range(99, 0) < p_in);
    in_data   = (src_q.size() > 0) ? src_q[0] : $urandom;
    aw_ready  = ($urandom_range(99, 0) < p_aw);
    w_ready   = ($urandom_range(99, 0) < p_w);
    if (wait_b) begin
      if (b_wait > 0) begin b_valid = 1'b0; b_wait--; end
      else b_valid = 1'b1;
      b_err = berr_mask[burst_idx % 32];
    end else begin
      b_valid = ($urandom_range(99, 0) < p_spur);
      b_err   = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic knobs(input int pi, input int pw, input int pa, input int bd, input int ps);
    p_in = pi; p_w = pw; p_aw = pa; bd_max = bd; p_spur = ps;
  endtask

  task automatic run_job(input logic [31:0] addr, input int len, input logic [31:0] base,
                         input bit rnd);
    int n, bad;
    logic [31:0] sent[$];
    aw_log_a.delete(); aw_log_l.delete(); w_log.delete(); wl_log.delete(); src_q.delete();
    done_cnt = 0; aw_seen = 0; err_at_done = 1'bx; cmd_cyc = -100; done_cyc = -1;
    job_started = 0;
    for (int i = 0; i < len; i++) src_q.push_back(rnd ? $urandom : base + 32'(i));
    sent = src_q;
    cmd_addr = addr; cmd_len = 16'(len); cmd_pend = 1; cmd_valid = 1'b1;
    n = 0;
    while (!(job_started && phase == 0) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL job_timeout actual=no_completion required=completion addr=0x%0h len=%0d",
               addr, len);
      do_reset();
    end
    chk("job_w_beats", 64'(w_log.size()), 64'(len));
    bad = 0;
    for (int i = 0; i < w_log.size() && i < sent.size(); i++)
      if (w_log[i] !== sent[i]) bad++;
    chk("job_word_order", 64'(bad), 64'(0));
    chk("job_done_pulses", 64'(done_cnt), 64'(1));
  endtask

  initial begin
    int n;
    knobs(100, 100, 100, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    // base case
    berr_mask = '0;
    run_job(32'h1000, 4, 32'hA0, 0);
    chk("base_aw_count", 64'(aw_log_a.size()), 64'(1));
    chk("base_aw", 64'({aw_log_a[0], aw_log_l[0]}), 64'({32'h1000, 8'd3}));
    chk("base_w0", 64'(w_log[0]), 64'(32'hA0));
    chk("base_w3", 64'(w_log[3]), 64'(32'hA3));
    for (int i = 0; i < 4; i++) chk("base_wlast", 64'(wl_log[i]), 64'(i == 3));
    chk("base_err", 64'(err_at_done), 64'(0));

    // length split
    run_job(32'h1000, 40, 32'h100, 0);
    chk("len_aw_count", 64'(aw_log_a.size()), 64'(3));
    chk("len_aw0", 64'({aw_log_a[0], aw_log_l[0]}), 64'({32'h1000, 8'd15}));
    chk("len_aw1", 64'({aw_log_a[1], aw_log_l[1]}), 64'({32'h1040, 8'd15}));
    chk("len_aw2", 64'({aw_log_a[2], aw_log_l[2]}), 64'({32'h1080, 8'd7}));

    // boundary split
    run_job(32'h1038, 10, 32'h200, 0);
    chk("bnd_aw_count", 64'(aw_log_a.size()), 64'(2));
    chk("bnd_aw0", 64'({aw_log_a[0], aw_log_l[0]}), 64'({32'h1038, 8'd1}));
    chk("bnd_aw1", 64'({aw_log_a[1], aw_log_l[1]}), 64'({32'h1040, 8'd7}));

    // address wrap
    run_job(32'hFFFF_FFF0, 20, 32'h300, 0);
    chk("wrap_aw0", 64'({aw_log_a[0], aw_log_l[0]}), 64'({32'hFFFF_FFF0, 8'd3}));
    chk("wrap_aw1", 64'({aw_log_a[1], aw_log_l[1]}), 64'({32'h0, 8'd15}));

    // backpressure
    knobs(60, 40, 50, 5, 20);
    run_job(32'h3000, 37, 32'h0, 1);

    // error on second of three bursts, then cleared by the next command
    knobs(100, 100, 100, 0, 0);
    berr_mask = 32'h2;
    run_job(32'h1000, 40, 32'h400, 0);
    chk("err_aw_count", 64'(aw_log_a.size()), 64'(3));
    chk("err_at_done", 64'(err_at_done), 64'(1));
    berr_mask = '0;
    run_job(32'h1000, 4, 32'h500, 0);
    chk("err_cleared", 64'(err_at_done), 64'(0));

    // zero-length job
    knobs(100, 100, 100, 0, 20);
    run_job(32'h5000, 0, 32'h0, 1);
    chk("zero_done_latency", 64'(done_cyc - cmd_cyc), 64'(1));
    chk("zero_no_aw", 64'(aw_seen), 64'(0));

    // reset in the middle of a burst
    knobs(100, 100, 100, 0, 0);
    w_log.delete(); wl_log.delete(); src_q.delete(); job_started = 0;
    for (int i = 0; i < 20; i++) src_q.push_back(32'h600 + 32'(i));
    cmd_addr = 32'h2000; cmd_len = 16'd20; cmd_pend = 1; cmd_valid = 1'b1;
    n = 0;
    while (w_log.size() < 3 && n < 200) begin
      step();
      n++;
    end
    chk("mid_reached_data", 64'(w_log.size() >= 3), 64'(1));
    do_reset();
    step();
    chk("mid_cmd_ready_release", 64'(cmd_ready), 64'(1));
    run_job(32'h1000, 8, 32'h700, 0);

    // random jobs
    for (int j = 0; j < 12; j++) begin
      logic [31:0] a;
      knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
            int'($urandom_range(100, 30)), int'($urandom_range(4, 0)), 20);
      berr_mask = $urandom;
      a = $urandom;
      if (j % 4 == 3) a = 32'hFFFF_FF00 | (a & 32'hFF);
      run_job(a, int'($urandom_range(70, 0)), 32'h0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ai_mc_wr_serializer.md
# ai_mc_wr_serializer

Write-back serializer for the memory controller. It consumes the valid-ready OFM word stream produced by the read arbiter and turns each write-back job into a sequence of single-outstanding write bursts on an AW/W/B memory port. Bursts are split at `MAX_BURST` beats and at `MAX_BURST`-aligned address boundaries. A small input FIFO decouples the BRAM read side from memory-port backpressure.

## Interface
**Parameters**
- `ADDR_W`, default 32: byte-address width.
- `LEN_W`, default 16: job length width, in beats.
- `DATA_W`, default 32: word width; `BPW = DATA_W/8` bytes per beat.
- `MAX_BURST`, default 16: maximum beats per burst; power of 2, at most 256.
- `FIFO_DEPTH`, default 4: input FIFO entries; power of 2.

**Ports**
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `cmd_valid`, in, 1 / `cmd_ready`, out, 1: job command handshake.
- `cmd_addr`, in, `ADDR_W`: job base byte address. The low log2(`BPW`) bits are ignored and treated as 0.
- `cmd_len`, in, `LEN_W`: job length in beats. 0 is a legal no-op.
- `in_valid`, in, 1 / `in_ready`, out, 1 / `in_data`, in, `DATA_W`: OFM word stream from the read arbiter.
- `aw_valid`, out, 1 / `aw_ready`, in, 1: burst address handshake.
- `aw_addr`, out, `ADDR_W`: burst start byte address.
- `aw_len`, out, 8: burst beats minus 1.
- `w_valid`, out, 1 / `w_ready`, in, 1 / `w_data`, out, `DATA_W` / `w_last`, out, 1: write data channel.
- `b_valid`, in, 1 / `b_ready`, out, 1 / `b_err`, in, 1: write response.
- `busy`, out, 1: a job is in progress.
- `done`, out, 1: one-cycle pulse at job completion.
- `err`, out, 1: sticky error flag; set if any burst of the job returned `b_err`.

## Operation
**FSM states:** IDLE, ADDR, DATA, RESP, FIN.
- **IDLE:** `cmd_ready=1`. On a command handshake:
  - latch the address and remaining = `cmd_len`;
  - clear the accepted-word count and `err`;
  - go to FIN if `cmd_len==0`, otherwise go to ADDR.
- **ADDR:** `aw_valid=1`.
  - Burst length = min(remaining, `MAX_BURST`, `MAX_BURST` − ((addr/`BPW`) mod `MAX_BURST`)).
  - `aw_addr` and `aw_len` are registered and held stable until `aw_ready`.
  - On the handshake: load the beat counter, go to DATA.
- **DATA:** `w_valid` = FIFO not empty; `w_data` = FIFO head.
  - `w_last=1` on the final beat of the burst.
  - On the last W handshake: go to RESP, addr += beats×`BPW`, remaining −= beats.
- **RESP:** `b_ready=1`. On `b_valid`:
  - `err |= b_err`;
  - go to ADDR if remaining≠0, otherwise go to FIN.
- **FIN:** `done=1` for exactly one cycle, then go to IDLE.

**Input FIFO**
- `in_ready` = (state≠IDLE and state≠FIN) and FIFO not full and accepted count < job length.
- The block never pulls words belonging to the next job.

**Other rules**
- `busy=1` in every state except IDLE.
- Address arithmetic wraps modulo 2^`ADDR_W`. No error is raised on wrap.
- Exactly one burst is outstanding at a time; the next AW is issued only after B.
- `b_valid` outside RESP is ignored. `b_ready=0` outside RESP.
- **Reset** (`rst`=0 at a clock edge):
  - all outputs go to 0 and the FIFO is emptied;
  - counters and `err` are cleared; the FSM goes to IDLE;
  - reset mid-burst abandons the burst with no further bus activity.
  - `cmd_ready` rises in the first cycle after `rst` returns to 1.

## Timing
- Command handshake at cycle C:
  - `aw_valid` is high in C+1;
  - with `cmd_len==0`, `done` is high in C+1 instead.
- AW handshake at cycle A: `w_valid` is eligible from A+1.
- An FIFO write at cycle N is visible at the FIFO head no earlier than N+1. There is no combinational path from `in_*` to `w_*`.
- Sustained throughput is 1 beat/cycle when the FIFO is non-empty and `w_ready=1`.
- Simultaneous FIFO push and pop when full is not possible, because `in_ready` is low when full. When the FIFO is non-full, simultaneous push and pop keep the count unchanged.
- B handshake at cycle R:
  - `aw_valid` is high in R+1 for the next burst;
  - after the final burst, `done` and `err` are valid in R+1, and `busy` falls in R+2 together with `cmd_ready` rising.

## Test plan
- Base case: `cmd_addr`=0x1000, `cmd_len`=4, words 0xA0..0xA3, all readies high.
  - Required: one AW with 0x1000, `aw_len`=3; W 0xA0..0xA3 with `w_last` only on 0xA3; `b_err`=0 gives a `done` pulse with `err`=0.
- Length split: `cmd_len`=40 at 0x1000, `MAX_BURST`=16.
  - Required: AWs (0x1000, 15), (0x1040, 15), (0x1080, 7); exactly 40 W beats, in order.
- Boundary split: `cmd_addr`=0x1038, `cmd_len`=10.
  - Required: AWs (0x1038, 1) then (0x1040, 7).
- Backpressure: random `in_valid`, `w_ready`, `aw_ready`, and `b_valid` delays; `cmd_len`=37.
  - Required: data order preserved; no drops or duplicates; `in_ready`=0 whenever the FIFO holds 4 words; `in_ready`=0 after the 37th word is accepted.
- Error: `b_err`=1 on the 2nd of 3 bursts.
  - Required: all 3 bursts are still issued; `err`=1 at `done`; the next command clears `err` to 0.
- Corner cases:
  - `cmd_len`=0 → `done` in C+1, `aw_valid` never asserted.
  - `rst`=0 in the middle of a DATA burst → all outputs 0 on the next edge; `cmd_ready`=1 in the first cycle after release.
